// File: rtl/cnt_meas_ctrl.sv
// Measurement sequencer for a 40-bit event counter. It clears the counter, gates
// events into it for a window or until stopped, then snapshots the settled count.
module cnt_meas_ctrl #(
  parameter int CNT_W = 40,
  parameter int WIN_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_clr,
  input  logic             i_event,
  input  logic [WIN_W-1:0] i_win_len,
  input  logic [CNT_W-1:0] i_cnt,
  output logic             o_sclr,
  output logic             o_cin,
  output logic             o_busy,
  output logic             o_done,
  output logic [CNT_W-1:0] o_snap,
  output logic             o_ovf
);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    RUN,
    SETTLE
  } state_e;

  state_e             state_q, state_d;
  logic [WIN_W-1:0]   winCnt_q, winCnt_d;
  logic [CNT_W-1:0]   snap_q, snap_d;
  logic               done_q, done_d;
  logic               ovf_q, ovf_d;
  logic               cinInt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      winCnt_q <= '0;
      snap_q   <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      winCnt_q <= winCnt_d;
      snap_q   <= snap_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
    end
  end

  assign cinInt = (state_q == RUN) && i_event && !i_clr;

  // A window count of zero means unbounded: only i_stop can end RUN then.
  always_comb begin
    state_d  = state_q;
    winCnt_d = winCnt_q;
    snap_d   = snap_q;
    done_d   = 1'b0;
    ovf_d    = ovf_q;

    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d  = CLEAR;
          winCnt_d = i_win_len;
        end
      end
      CLEAR: begin
        state_d = RUN;
        ovf_d   = 1'b0;
      end
      RUN: begin
        if (winCnt_q != '0) begin
          winCnt_d = winCnt_q - 1'b1;
        end
        if (cinInt && (&i_cnt)) begin
          ovf_d = 1'b1;
        end
        if (i_stop || (winCnt_q == WIN_W'(1))) begin
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        state_d = IDLE;
        snap_d  = i_cnt;
        done_d  = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort overrides everything but keeps the last valid snapshot.
    if (i_clr) begin
      state_d = IDLE;
      ovf_d   = 1'b0;
      done_d  = 1'b0;
      snap_d  = snap_q;
    end
  end

  assign o_sclr = i_rst || i_clr || (state_q == CLEAR);
  assign o_cin  = cinInt;
  assign o_busy = (state_q != IDLE);
  assign o_done = done_q;
  assign o_snap = snap_q;
  assign o_ovf  = ovf_q;

endmodule

// File: tb/tb_cnt_meas_ctrl.sv
// Self-checking bench for cnt_meas_ctrl: a behavioural counter sits on the
// counter interface and each measurement's snapshot is predicted from event counts.
module tb_cnt_meas_ctrl;

  localparam int CNT_W = 40;
  localparam int WIN_W = 16;

  logic             i_clk;
  logic             i_rst;
  logic             i_start;
  logic             i_stop;
  logic             i_clr;
  logic             i_event;
  logic [WIN_W-1:0] i_win_len;
  logic [CNT_W-1:0] i_cnt;
  logic             o_sclr;
  logic             o_cin;
  logic             o_busy;
  logic             o_done;
  logic [CNT_W-1:0] o_snap;
  logic             o_ovf;

  logic [CNT_W-1:0] cntModel;
  logic             stubMode;
  logic [CNT_W-1:0] stubVal;
  logic [CNT_W-1:0] lastSnap;
  int               checkCount;
  int               passCount;

  cnt_meas_ctrl #(.CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_start  (i_start),
    .i_stop   (i_stop),
    .i_clr    (i_clr),
    .i_event  (i_event),
    .i_win_len(i_win_len),
    .i_cnt    (i_cnt),
    .o_sclr   (o_sclr),
    .o_cin    (o_cin),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_snap   (o_snap),
    .o_ovf    (o_ovf)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Stand-in for the real counter: sync clear, count enable, wraps naturally.
  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst)       cntModel <= '0;
    else if (o_sclr) cntModel <= '0;
    else if (o_cin)  cntModel <= cntModel + 1'b1;
  end

  assign i_cnt = stubMode ? stubVal : cntModel;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp)
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    else
      passCount++;
  endtask

  // One full measurement; stopAt=0 means no stop, evMode 0=random 1=always 2=toggle.
  task automatic applyStimulus(input int winLen, input int stopAt, input int evMode,
                               input bit startInRun, input bit stub);
    int limit;
    int expEv;
    int dutCin;
    bit ev;
    logic [CNT_W-1:0] expSnap;
    bit expOvf;
    if (winLen == 0)                       limit = stopAt;
    else if (stopAt != 0 && stopAt < winLen) limit = stopAt;
    else                                   limit = winLen;
    stubMode = stub;
    @(posedge i_clk); #1;
    i_start   = 1'b1;
    i_win_len = WIN_W'(winLen);
    i_event   = 1'b0;
    i_stop    = 1'b0;
    @(posedge i_clk); #1;
    i_start   = 1'b0;
    i_win_len = WIN_W'($urandom);
    #1;
    checkOutput("clearSclr", {63'd0, o_sclr}, 64'd1);
    expEv  = 0;
    dutCin = 0;
    for (int c = 1; c <= limit + 2; c++) begin
      @(posedge i_clk); #1;
      case (evMode)
        0:       ev = 1'($urandom_range(0, 1));
        1:       ev = 1'b1;
        default: ev = (c % 2) == 1;
      endcase
      i_event = ev;
      i_stop  = (c == stopAt);
      i_start = startInRun && (c == 2) && (c <= limit);
      #1;
      if (c <= limit && ev) expEv++;
      if (o_cin) dutCin++;
      if (c == 1) begin
        checkOutput("runOvfCleared", {63'd0, o_ovf}, 64'd0);
        checkOutput("runSclrLow", {63'd0, o_sclr}, 64'd0);
      end
      if (c == limit + 1) begin
        checkOutput("settleNoDone", {63'd0, o_done}, 64'd0);
        checkOutput("settleBusy", {63'd0, o_busy}, 64'd1);
      end
      if (c == limit + 2) begin
        expSnap = stub ? stubVal : CNT_W'(expEv);
        expOvf  = stub && (expEv > 0);
        checkOutput("donePulse", {63'd0, o_done}, 64'd1);
        checkOutput("doneSnap", 64'(o_snap), 64'(expSnap));
        checkOutput("doneOvf", {63'd0, o_ovf}, {63'd0, expOvf});
        checkOutput("doneIdle", {63'd0, o_busy}, 64'd0);
        lastSnap = expSnap;
      end
    end
    i_event = 1'b0;
    i_stop  = 1'b0;
    i_start = 1'b0;
    checkOutput("cinCycles", 64'(dutCin), 64'(expEv));
    @(posedge i_clk); #2;
    checkOutput("doneOneCycle", {63'd0, o_done}, 64'd0);
  endtask

  initial begin
    int wl;
    int sa;
    int doneSeen;
    checkCount = 0;
    passCount  = 0;
    i_rst      = 1'b1;
    i_start    = 1'b0;
    i_stop     = 1'b0;
    i_clr      = 1'b0;
    i_event    = 1'b0;
    i_win_len  = '0;
    stubMode   = 1'b0;
    stubVal    = {CNT_W{1'b1}};
    lastSnap   = '0;
    #12;
    checkOutput("rstBusy", {63'd0, o_busy}, 64'd0);
    checkOutput("rstSnap", 64'(o_snap), 64'd0);
    checkOutput("rstDone", {63'd0, o_done}, 64'd0);
    checkOutput("rstOvf", {63'd0, o_ovf}, 64'd0);
    checkOutput("rstSclr", {63'd0, o_sclr}, 64'd1);
    @(negedge i_clk);
    i_rst = 1'b0;

    $display("[TB] window of 10, constant events");
    applyStimulus(10, 0, 1, 1'b0, 1'b0);

    $display("[TB] unbounded window, toggling events, stop in cycle 7");
    applyStimulus(0, 7, 2, 1'b0, 1'b0);
    checkOutput("toggleSnapFour", 64'(lastSnap), 64'd4);

    $display("[TB] overflow with stubbed all-ones count");
    applyStimulus(5, 0, 1, 1'b0, 1'b1);
    checkOutput("ovfSticky", {63'd0, o_ovf}, 64'd1);
    applyStimulus(4, 0, 0, 1'b0, 1'b0);

    $display("[TB] stop in idle is ignored");
    @(posedge i_clk); #1;
    i_stop = 1'b1;
    @(posedge i_clk); #1;
    i_stop = 1'b0;
    checkOutput("idleStopIgnored", {63'd0, o_busy}, 64'd0);

    $display("[TB] abort with clear and stop in RUN cycle 3");
    @(posedge i_clk); #1;
    i_start   = 1'b1;
    i_win_len = '0;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(posedge i_clk); #1;
      i_event = 1'b1;
      if (c == 3) begin
        i_clr  = 1'b1;
        i_stop = 1'b1;
        #1;
        checkOutput("abortSclr", {63'd0, o_sclr}, 64'd1);
        checkOutput("abortNoCin", {63'd0, o_cin}, 64'd0);
      end
    end
    @(posedge i_clk); #1;
    i_clr   = 1'b0;
    i_stop  = 1'b0;
    i_event = 1'b0;
    checkOutput("abortIdle", {63'd0, o_busy}, 64'd0);
    doneSeen = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge i_clk); #1;
      if (o_done) doneSeen++;
    end
    checkOutput("abortNoDone", 64'(doneSeen), 64'd0);
    checkOutput("abortSnapKept", 64'(o_snap), 64'(lastSnap));

    $display("[TB] randomized measurements");
    for (int n = 0; n < 10; n++) begin
      wl = $urandom_range(0, 20);
      if (wl == 0) sa = $urandom_range(1, 20);
      else         sa = $urandom_range(0, 25);
      applyStimulus(wl, sa, 0, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("[TB] asynchronous reset mid-run");
    @(posedge i_clk); #1;
    i_start   = 1'b1;
    i_win_len = '0;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    i_event = 1'b1;
    @(posedge i_clk); @(posedge i_clk); #3;
    i_rst = 1'b1;
    #1;
    checkOutput("asyncBusy", {63'd0, o_busy}, 64'd0);
    checkOutput("asyncSnap", 64'(o_snap), 64'd0);
    checkOutput("asyncOvf", {63'd0, o_ovf}, 64'd0);
    checkOutput("asyncSclr", {63'd0, o_sclr}, 64'd1);
    @(posedge i_clk); #1;
    checkOutput("asyncSclrHeld", {63'd0, o_sclr}, 64'd1);
    @(negedge i_clk);
    i_rst   = 1'b0;
    i_event = 1'b0;
    lastSnap = '0;
    applyStimulus(3, 0, 1, 1'b0, 1'b0);
    checkOutput("postRstSnap", 64'(lastSnap), 64'd3);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
